// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: queues fetch-time predictions in order, checks them
// against execute outcomes, and drives BHT updates, flush/redirect and statistics.
module branch_resolution_unit #(
  parameter int PC_W  = 32,
  parameter int LOWER = 7,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_target,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  output logic             full,
  output logic             empty,
  output logic             bht_upd_valid,
  output logic [LOWER-1:0] bht_write_addr,
  output logic             bht_was_taken,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             underflow_err,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic            taken_mem [DEPTH];
  logic [PC_W-1:0] tgt_mem   [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic            pop;
  logic            push;
  logic            mis;
  logic [PC_W-1:0] e_pc;
  logic            e_taken;
  logic [PC_W-1:0] e_tgt;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Handshake: pred_valid is accepted when !full, or when a pop frees a slot in
  // the same cycle; res_valid is consumed only when !empty (else it is an underflow).
  assign pop  = en & res_valid & ~empty;
  assign push = en & pred_valid & (~full | pop);

  assign e_pc    = pc_mem[rd_ptr];
  assign e_taken = taken_mem[rd_ptr];
  assign e_tgt   = tgt_mem[rd_ptr];

  // The predicted target only matters when both sides agree the branch is taken.
  assign mis = pop & ((e_taken != res_taken) |
                      (e_taken & res_taken & (e_tgt != res_target)));

  always_ff @(posedge clk) begin
    if (push && !mis) begin
      pc_mem[wr_ptr]    <= pred_pc;
      taken_mem[wr_ptr] <= pred_taken;
      tgt_mem[wr_ptr]   <= pred_target;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      bht_upd_valid    <= 1'b0;
      bht_write_addr   <= '0;
      bht_was_taken    <= 1'b0;
      flush            <= 1'b0;
      redirect_pc      <= '0;
      underflow_err    <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (en) begin
      bht_upd_valid <= pop;
      flush         <= mis;
      if (res_valid && empty) underflow_err <= 1'b1;
      if (pop) begin
        bht_write_addr <= e_pc[LOWER-1:0];
        bht_was_taken  <= res_taken;
        if (!(&branch_count)) branch_count <= branch_count + 1'b1;
      end
      if (mis) begin
        redirect_pc <= res_taken ? res_target : e_pc + PC_W'(4);
        if (!(&mispredict_count)) mispredict_count <= mispredict_count + 1'b1;
        // Everything still queued is wrong-path, including a same-cycle push.
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Consumer and updater of the 2-bit-counter branch history table.
- Queues every prediction issued at fetch (PC, predicted direction, predicted target) in a small in-order FIFO.
- When a branch or jump resolves in execute, pops the oldest entry and compares prediction against outcome.
- Produces the table update (write address, taken flag), a pipeline flush and redirect PC on mispredict, plus saturating statistics counters.

Parameters:
- PC_W, 32, program counter width in bits.
- LOWER, 7, width of the table write address; equals the low PC bits used to index the table.
- DEPTH, 4, number of in-flight prediction entries; power of two, minimum 2.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; when 0 all state holds and registered outputs hold.
- pred_valid  in  1  fetch issues a predicted control-flow instruction this cycle.
- pred_pc  in  PC_W  PC of that instruction.
- pred_taken  in  1  predicted direction (table prediction bit).
- pred_target  in  PC_W  predicted target, used only when pred_taken=1.
- res_valid  in  1  execute resolves the oldest in-flight entry this cycle.
- res_taken  in  1  actual direction (branch taken or unconditional jump).
- res_target  in  PC_W  actual target when res_taken=1.
- full  out  1  FIFO holds DEPTH entries (combinational from count).
- empty  out  1  FIFO holds 0 entries (combinational from count).
- bht_upd_valid  out  1  registered; pulses one cycle per resolved entry.
- bht_write_addr  out  LOWER  registered; pred_pc[LOWER-1:0] of the resolved entry.
- bht_was_taken  out  1  registered; res_taken of the resolved entry.
- flush  out  1  registered; one-cycle mispredict pulse.
- redirect_pc  out  PC_W  registered; valid while flush=1.
- underflow_err  out  1  sticky; set when res_valid arrives while empty.
- branch_count  out  CNT_W  resolved entries, saturating.
- mispredict_count  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset (arst_n=0, async):
  - FIFO pointers and count go to 0.
  - All registered outputs, both counters and underflow_err go to 0.
  - The pointer clear discards any entry in flight, including one mid-push or mid-pop.
- en=0: no push, no pop, no update; every register holds.
- Push: on a rising edge with en=1 and pred_valid=1 and (full=0, or a pop occurs in the same cycle), write {pred_pc, pred_taken, pred_target} at the write pointer. A push while full with no pop is dropped; the issuing stage must stall on full.
- Pop: on a rising edge with en=1, res_valid=1 and empty=0, read the entry at the read pointer.
  - Direction mispredict: pred_taken != res_taken.
  - Target mispredict: pred_taken = res_taken = 1 and pred_target != res_target.
- Update, one cycle after the pop:
  - bht_upd_valid=1, bht_write_addr = entry pc[LOWER-1:0], bht_was_taken = res_taken.
  - branch_count increments unless it is all-ones.
- Mispredict, one cycle after the pop:
  - flush=1 for exactly one cycle.
  - redirect_pc = res_target if res_taken=1, else entry pc + 4, modulo 2^PC_W so it wraps at the top.
  - mispredict_count increments unless it is all-ones.
  - On the same edge all remaining FIFO entries are discarded (count=0, read pointer = write pointer), because they are wrong-path.
  - A push in that same cycle is discarded too.
- Correct prediction: flush=0 and redirect_pc holds its previous value.
- Underflow: res_valid=1 while empty sets underflow_err, which stays set until reset. No update pulse and no counter change.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Simultaneous push and pop with no mispredict: count is unchanged and both pointers advance.

Test Plan:
- Push pc=0x40 taken=0; resolve res_taken=0 -> next cycle bht_upd_valid=1, bht_write_addr=0x40, bht_was_taken=0, flush=0, branch_count=1.
- Push pc=0x10 taken=0; resolve res_taken=1, res_target=0x80 -> next cycle flush=1, redirect_pc=0x80, mispredict_count=1; flush=0 the cycle after.
- Push pc=0x20 taken=1, target=0x100; resolve taken=1, target=0x104 -> flush=1, redirect_pc=0x104.
- Push 4 entries -> full=1; 5th push dropped. Resolve the first as a mispredict (pc=0x0, predicted taken, actual not taken) with pred_valid=1 the same cycle -> redirect_pc=0x4, empty=1 afterwards, the same-cycle push is lost.
- res_valid with empty=1 -> underflow_err=1 and stays 1, branch_count unchanged. Assert arst_n=0 mid-stream with 3 entries -> empty=1, all outputs 0 immediately.
- Preload branch_count to all-ones via 2^CNT_W resolves (use CNT_W=4: 16 resolves) -> 17th resolve leaves branch_count=0xF. Sustained push/pop every cycle for 10 cycles keeps count constant and pointers wrap.
